// File: rtl/tx_serial_pkg.sv
// Shared definitions for the parametrised serial transmitter: parity modes,
// FSM state encoding and a helper that gives the number of bits in a frame.
package tx_serial_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_FIM    = 3'd5
  } state_t;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int nbits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter used as the baud timer. It counts 0..M-1 while enabled,
// can be cleared at any time, and flags the last count of each bit period.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  localparam logic [N-1:0] LAST = N'(M - 1);

  // Next count: clear has priority, otherwise count up and wrap at M-1.
  always_comb begin
    count_d = count_q;
    if (zera) begin
      count_d = '0;
    end else if (conta) begin
      count_d = (count_q == LAST) ? '0 : count_q + N'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim = (count_q == LAST);

endmodule

// File: rtl/tx_serial_uart_param.sv
// Parametrised asynchronous serial transmitter. Sends start bit, data LSB
// first, optional parity and one or two stop bits. All outputs are registered,
// so each output reflects the FSM state of the previous cycle.
module tx_serial_uart_param
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  // Reject illegal configurations while elaborating.
  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      CLKS_PER_BIT < 2) begin : g_param_check
    $error("tx_serial_uart_param: illegal parameter combination");
  end

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 saida_q, saida_d;
  logic                 ocupado_q, ocupado_d;
  logic                 pronto_q, pronto_d;

  logic accept;
  logic baud_fim;
  logic baud_clear;
  logic baud_en;

  assign accept     = partida && ((state_q == ST_IDLE) || (state_q == ST_FIM));
  assign baud_en    = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign baud_clear = accept || (state_d != state_q);

  contador_m #(
    .M (CLKS_PER_BIT),
    .N (BAUD_W)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .zera  (baud_clear),
    .conta (baud_en),
    .fim   (baud_fim)
  );

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each bit lasts one baud period, FIM lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (partida) state_d = ST_START;
      ST_START:  if (baud_fim) state_d = ST_DATA;
      ST_DATA: begin
        if (baud_fim && (bit_cnt_q == LAST_BIT)) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (baud_fim) state_d = ST_STOP;
      ST_STOP:   if (baud_fim && (stop_cnt_q == LAST_STOP)) state_d = ST_FIM;
      ST_FIM:    state_d = partida ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode, one cycle ahead of the registered pins.
  always_comb begin
    saida_d   = 1'b1;
    ocupado_d = 1'b0;
    pronto_d  = 1'b0;
    case (state_q)
      ST_START: begin
        saida_d   = 1'b0;
        ocupado_d = 1'b1;
      end
      ST_DATA: begin
        saida_d   = shift_q[0];
        ocupado_d = 1'b1;
      end
      ST_PARITY: begin
        saida_d   = parity_q;
        ocupado_d = 1'b1;
      end
      ST_STOP: begin
        ocupado_d = 1'b1;
      end
      ST_FIM: begin
        pronto_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath: capture word and parity on accept, shift and count per bit.
  always_comb begin
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    if (accept) begin
      shift_d    = dados;
      parity_d   = (PARITY == PAR_ODD) ? ~^dados : ^dados;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end else if ((state_q == ST_DATA) && baud_fim) begin
      shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end else if ((state_q == ST_STOP) && baud_fim) begin
      stop_cnt_d = stop_cnt_q + 1'b1;
    end
  end

  // Datapath and output registers; line idles high out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      saida_q    <= 1'b1;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      saida_q    <= saida_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
    end
  end

  assign saida_serial = saida_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;

endmodule
